// File: rtl/lock_pkg.sv
// ============================================================================
// lock_pkg : shared widths and state encodings for the code-entry lock path
// Revision : 1.0
// ============================================================================
`default_nettype none

package lock_pkg;

  localparam int DIGIT_W     = 2;
  localparam int CODE_DIGITS = 4;
  localparam int CODE_W      = DIGIT_W * CODE_DIGITS;
  localparam int CNT_W       = 3;

  typedef enum logic {
    PRESS_IDLE = 1'b0,
    PRESS_HELD = 1'b1
  } press_state_e;

  // Consumed by the downstream lock FSM, which compares only when code_full=1.
  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    INPUT    = 3'd1,
    VERIFY   = 3'd2,
    ERROR    = 3'd3,
    UNLOCKED = 3'd4
  } lock_state_e;

endpackage : lock_pkg

`default_nettype wire

// File: rtl/btn_encoder.sv
// ============================================================================
// btn_encoder : one-hot keypad to digit index, plus legality and any-press flags
// Revision    : 1.0
// ============================================================================
`default_nettype none

module btn_encoder
  import lock_pkg::*;
(
  input  logic [3:0]         btn,
  output logic [DIGIT_W-1:0] digit,
  output logic               one_hot,
  output logic               any
);

  // digit is only meaningful when one_hot is set.
  always_comb begin
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn[i]) digit = DIGIT_W'(i);
    end
  end

  assign one_hot = ($countones(btn) == 1);
  assign any     = |btn;

endmodule : btn_encoder

`default_nettype wire

// File: rtl/code_entry.sv
// ============================================================================
// code_entry : edge-detected keypad capture into a 4-digit code shift register
// Revision   : 1.0
// ============================================================================
`default_nettype none

module code_entry
  import lock_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic              capture_en,
  input  logic              clear,
  output logic [CODE_W-1:0] entered_code,
  output logic [CNT_W-1:0]  digit_count,
  output logic              code_full,
  output logic              key_valid,
  output logic              invalid_press,
  output logic              input_error
);

  logic [DIGIT_W-1:0] w_digit;
  logic               w_one_hot;
  logic               w_any;
  logic               w_press;

  press_state_e       state_q;
  logic [CODE_W-1:0]  code_q;
  logic [CNT_W-1:0]   count_q;
  logic               key_valid_q;
  logic               invalid_q;
  logic               error_q;

  btn_encoder u_btn_encoder (
    .btn     (btn),
    .digit   (w_digit),
    .one_hot (w_one_hot),
    .any     (w_any)
  );

  assign w_press = (state_q == PRESS_IDLE) && w_any;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PRESS_IDLE;
      code_q      <= '0;
      count_q     <= '0;
      key_valid_q <= 1'b0;
      invalid_q   <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      invalid_q   <= 1'b0;

      // Press tracking runs regardless of clear/capture_en so a held key never re-fires.
      case (state_q)
        PRESS_IDLE: if (w_any)  state_q <= PRESS_HELD;
        PRESS_HELD: if (!w_any) state_q <= PRESS_IDLE;
        default:                state_q <= PRESS_IDLE;
      endcase

      if (clear) begin
        code_q  <= '0;
        count_q <= '0;
        error_q <= 1'b0;
      end else if (w_press && capture_en) begin
        if (!w_one_hot) begin
          invalid_q <= 1'b1;
          error_q   <= 1'b1;
        end else if (count_q < CNT_W'(CODE_DIGITS)) begin
          code_q      <= {code_q[CODE_W-DIGIT_W-1:0], w_digit};
          count_q     <= count_q + CNT_W'(1);
          key_valid_q <= 1'b1;
        end else begin
          error_q <= 1'b1;
        end
      end
    end
  end

  assign entered_code  = code_q;
  assign digit_count   = count_q;
  assign code_full     = (count_q == CNT_W'(CODE_DIGITS));
  assign key_valid     = key_valid_q;
  assign invalid_press = invalid_q;
  assign input_error   = error_q;

endmodule : code_entry

`default_nettype wire

// File: tb/tb_code_entry.sv
// ============================================================================
// tb_code_entry : scoreboard bench for code_entry against a digit-list model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_code_entry;

  typedef struct packed {
    logic [7:0] code;
    logic [2:0] cnt;
    logic       full;
    logic       kv;
    logic       ip;
    logic       err;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic       capture_en;
  logic       clear;
  logic [7:0] entered_code;
  logic [2:0] digit_count;
  logic       code_full;
  logic       key_valid;
  logic       invalid_press;
  logic       input_error;

  code_entry dut (
    .clk           (clk),
    .reset         (reset),
    .btn           (btn),
    .capture_en    (capture_en),
    .clear         (clear),
    .entered_code  (entered_code),
    .digit_count   (digit_count),
    .code_full     (code_full),
    .key_valid     (key_valid),
    .invalid_press (invalid_press),
    .input_error   (input_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   kv_seen;
  int   cyc;

  // Reference model: a list of accepted digits, a sticky error and "button was down last clock".
  int   m_digits[$];
  bit   m_prev_down;
  bit   m_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] b, input logic cap, input logic clr, input logic rst);
    exp_t e;
    bit   press;
    bit   kv;
    bit   ip;
    int   code;
    @(negedge clk);
    btn = b; capture_en = cap; clear = clr; reset = rst;
    kv = 0; ip = 0;
    if (rst) begin
      m_prev_down = 0;
      m_digits.delete();
      m_err = 0;
    end else begin
      press       = !m_prev_down && (b != 4'd0);
      m_prev_down = (b != 4'd0);
      if (clr) begin
        m_digits.delete();
        m_err = 0;
      end else if (press && cap) begin
        if ($countones(b) != 1) begin
          ip = 1; m_err = 1;
        end else if (m_digits.size() < 4) begin
          for (int i = 0; i < 4; i++) if (b[i]) m_digits.push_back(i);
          kv = 1;
        end else begin
          m_err = 1;
        end
      end
    end
    code = 0;
    foreach (m_digits[i]) code += m_digits[i] * (4 ** (m_digits.size() - 1 - i));
    e.code = 8'(code);
    e.cnt  = 3'(m_digits.size());
    e.full = (m_digits.size() == 4);
    e.kv   = kv;
    e.ip   = ip;
    e.err  = m_err;
    sb.push_back(e);
  endtask

  task automatic tap(input logic [3:0] b, input int hold);
    for (int i = 0; i < hold; i++) drive(b, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle with a pending expectation, compare the full output set.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {entered_code, digit_count, code_full, key_valid, invalid_press, input_error};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got code=%h cnt=%0d full=%b kv=%b ip=%b err=%b expected code=%h cnt=%0d full=%b kv=%b ip=%b err=%b",
                   cyc, a.code, a.cnt, a.full, a.kv, a.ip, a.err, e.code, e.cnt, e.full, e.kv, e.ip, e.err);
        end
        if (key_valid === 1'b1) kv_seen++;
      end
    end
  end

  initial begin
    int kv0;
    int r;
    int hold;
    logic [3:0] b;
    logic cap, clr, rst;
    btn = '0; capture_en = 1'b0; clear = 1'b0; reset = 1'b1;
    checks = 0; errors = 0; kv_seen = 0; cyc = 0;
    m_prev_down = 0; m_err = 0;

    drive(4'd0, 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0, 1'b1);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("reset_code", entered_code, 0);
    chk("reset_count", digit_count, 0);

    // Four-digit entry 0,2,3,1
    kv0 = kv_seen;
    tap(4'b0001, 1); tap(4'b0100, 1); tap(4'b1000, 1); tap(4'b0010, 1);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("seq_code", entered_code, 8'h2D);
    chk("seq_count", digit_count, 4);
    chk("seq_full", code_full, 1);
    chk("seq_kv_pulses", kv_seen - kv0, 4);

    // Overrun on a full code
    tap(4'b1000, 1);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("overrun_code", entered_code, 8'h2D);
    chk("overrun_err", input_error, 1);
    chk("overrun_kv", kv_seen - kv0, 4);

    // Clear, then a long hold yields a single digit
    drive(4'd0, 1'b1, 1'b1, 1'b0);
    kv0 = kv_seen;
    tap(4'b0100, 10);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("hold_kv_pulses", kv_seen - kv0, 1);
    chk("hold_digit", entered_code[1:0], 2);
    chk("hold_count", digit_count, 1);

    // Multi-button press, then clear
    tap(4'b0011, 2);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("multi_err", input_error, 1);
    chk("multi_count", digit_count, 1);
    drive(4'd0, 1'b1, 1'b1, 1'b0);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("clear_err", input_error, 0);
    chk("clear_code", entered_code, 0);

    // Press coinciding with clear after two digits; holding must not re-fire
    tap(4'b0010, 1); tap(4'b1000, 1);
    kv0 = kv_seen;
    drive(4'b0001, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(4'b0001, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("clr_press_count", digit_count, 0);
    chk("clr_press_kv", kv_seen - kv0, 0);

    // capture_en low ignores presses; reset mid-entry
    tap(4'b0001, 1); tap(4'b0010, 1); tap(4'b0100, 1);
    drive(4'b0010, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    drive(4'd0, 1'b0, 1'b0, 1'b0);
    chk("capoff_count", digit_count, 3);
    chk("capoff_code", entered_code, 8'h06);
    drive(4'b1000, 1'b1, 1'b0, 1'b1);
    drive(4'b1000, 1'b1, 1'b0, 1'b0);
    chk("reset_mid_count", digit_count, 0);
    chk("reset_mid_code", entered_code, 0);
    drive(4'd0, 1'b1, 1'b0, 1'b0);
    chk("held_through_reset", digit_count, 1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      b = 4'd0;
      else if (r < 85) b = 4'(1 << $urandom_range(0, 3));
      else             b = 4'($urandom_range(1, 15));
      cap  = ($urandom_range(0, 9) != 0);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        clr = ($urandom_range(0, 29) == 0);
        rst = ($urandom_range(0, 199) == 0);
        drive(b, cap, clr, rst);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_code_entry

`default_nettype wire

// File: doc/code_entry.md
CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: btn  input  4  raw keypad buttons, one-hot when legal; bit i selects digit i.
REQ-005 Port: capture_en  input  1  high while the downstream lock FSM is in INPUT; enables digit storage.
REQ-006 Port: clear  input  1  discards the entered code.
REQ-007 Port: entered_code  output  8  four 2-bit digits; first-entered digit in [7:6], last in [1:0].
REQ-008 Port: digit_count  output  3  number of digits stored, 0..4.
REQ-009 Port: code_full  output  1  high when digit_count == 4.
REQ-010 Port: key_valid  output  1  one-cycle pulse when a legal digit is accepted.
REQ-011 Port: invalid_press  output  1  one-cycle pulse on a multi-button press.
REQ-012 Port: input_error  output  1  sticky flag: an invalid press or an overrun occurred since the last clear or reset.

Function
REQ-013 Press detection SHALL use a two-state FSM: IDLE (btn == 0 at the last clock) and HELD (btn != 0 at the last clock).
REQ-014 A press event SHALL occur only on a clock where the FSM is in IDLE and btn != 0; the FSM then enters HELD.
REQ-015 In HELD, the FSM SHALL stay in HELD while btn != 0 and return to IDLE on the first clock with btn == 0; no events are generated in HELD.
REQ-016 On a press event where popcount(btn) == 1, the digit SHALL be encoded as the set bit's index: 0001->0, 0010->1, 0100->2, 1000->3.
REQ-017 Legal press with capture_en=1 and digit_count<4: at that clock edge, entered_code <= {entered_code[5:0], digit}, digit_count increments, and key_valid pulses for one cycle (1-cycle latency from the sampled edge).
REQ-018 Press event with popcount(btn) > 1: no digit is stored, invalid_press pulses for one cycle, and input_error is set.
REQ-019 Legal press with capture_en=1 and digit_count==4 (overrun): the digit is dropped, entered_code is unchanged, key_valid stays 0, and input_error is set.
REQ-020 Any press event with capture_en=0 SHALL be ignored for storage and flags, but the FSM SHALL still move to HELD.
REQ-021 clear=1 SHALL set entered_code=0, digit_count=0 and input_error=0 at the next edge, and suppress key_valid and invalid_press on that cycle.
REQ-022 When clear and a press event coincide, clear SHALL win, but the press still moves the FSM to HELD, so holding the button generates no later event.
REQ-023 code_full SHALL be combinational from digit_count; the count SHALL saturate at 4 and never wrap.
REQ-024 Deasserting capture_en SHALL NOT alter entered_code or digit_count; only clear or reset does.

Reset
REQ-025 On reset, the block SHALL set: FSM=IDLE, entered_code=8'h00, digit_count=0, code_full=0, key_valid=0, invalid_press=0, input_error=0.
REQ-026 Reset SHALL take precedence over clear and over press events.
REQ-027 If btn is held through reset release, the FSM SHALL still start in IDLE, so a single press event is generated on the first clock after release.

Structure
REQ-028 A shared package lock_pkg SHALL hold: DIGIT_W=2, CODE_DIGITS=4, CODE_W=8, the press-FSM state encoding, and the lock FSM state constants LOCKED, INPUT, VERIFY, ERROR, UNLOCKED.
REQ-029 The one-hot-to-binary encoder and popcount check SHALL be one combinational sub-module, btn_encoder, with outputs digit[1:0], one_hot and any.
REQ-030 The downstream lock FSM SHALL compare entered_code against its password only when code_full=1.

Verification
REQ-031 With capture_en=1, press-release 0001, 0100, 1000, 0010 -> entered_code=8'h2D, digit_count=4, code_full=1, four key_valid pulses.
REQ-032 Hold 0100 for 10 cycles, then release -> exactly one key_valid; entered_code[1:0]=2; digit_count=1.
REQ-033 Press 0011 -> invalid_press pulses once, input_error=1, digit_count unchanged; then clear -> input_error=0, entered_code=0.
REQ-034 After four legal digits, press 1000 -> key_valid=0, entered_code stays 8'h2D, input_error=1.
REQ-035 Press 0001 on the same clock as clear=1 after two digits -> digit_count=0 and no key_valid, including while 0001 stays held.
REQ-036 With capture_en=0, press 0010 -> no outputs change; assert reset mid-entry (count=3) -> all outputs 0 on the next edge.
